// File: rtl/rpc_cmd_timer.sv
// rpc_cmd_timer: accepts one decoded DRAM command at a time, presents it to
// the PHY issue stage, then blocks the next command until that command's
// timing window (tRP, tRCD, tMRD, burst, tRFC, tZQC, tRESET) has elapsed.

package rpc_cmd_pkg;
  localparam logic [3:0] CMD_INVALID = 4'h0;
  localparam logic [3:0] CMD_PRE     = 4'h1;
  localparam logic [3:0] CMD_ACT     = 4'h2;
  localparam logic [3:0] CMD_MRS     = 4'h3;
  localparam logic [3:0] CMD_RD      = 4'h4;
  localparam logic [3:0] CMD_WR      = 4'h5;
  localparam logic [3:0] CMD_REF     = 4'h6;
  localparam logic [3:0] CMD_ZQC     = 4'h7;
  localparam logic [3:0] CMD_RESET   = 4'h8;
endpackage

module rpc_cmd_timer
  import rpc_cmd_pkg::*;
#(
  parameter int T_RP    = 4,
  parameter int T_RCD   = 6,
  parameter int T_MRD   = 4,
  parameter int T_RW    = 3,
  parameter int T_RFC   = 16,
  parameter int T_ZQCS  = 32,
  parameter int T_ZQCL  = 128,
  parameter int T_RESET = 200,
  parameter int CNT_W   = 12
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [3:0] cmd_decoded_i,
  input  logic [5:0] burst_length_i,
  input  logic [1:0] zqc_mode_i,
  input  logic [3:0] ref_bank_num_i,
  output logic       issue_valid_o,
  input  logic       issue_ready_i,
  output logic [3:0] issue_cmd_o,
  output logic       busy_o,
  output logic       err_invalid_o
);

  // Intermediate width leaves headroom so products/sums saturate instead of wrapping.
  localparam int XW = CNT_W + 4;
  localparam logic [XW-1:0] MAX_D = XW'((1 << CNT_W) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_dur;
  logic [3:0]       r_cmd;
  logic             r_err;

  logic             w_accept;
  logic             w_isInvalid;
  logic             w_issueHs;
  logic [XW-1:0]    w_banks;
  logic [XW-1:0]    w_raw;
  logic [CNT_W-1:0] w_dur;

  assign w_accept    = cmd_valid_i && (r_state == IDLE);
  assign w_isInvalid = (cmd_decoded_i == CMD_INVALID);
  assign w_issueHs   = (r_state == ISSUE) && issue_ready_i;

  // Wait duration of the incoming command, clamped to [1, 2^CNT_W-1].
  always_comb begin
    w_banks = XW'(ref_bank_num_i);
    if (ref_bank_num_i == 4'd0) begin
      w_banks = XW'(1);
    end
    w_raw = '0;
    case (cmd_decoded_i)
      CMD_PRE:        w_raw = XW'(T_RP);
      CMD_ACT:        w_raw = XW'(T_RCD);
      CMD_MRS:        w_raw = XW'(T_MRD);
      CMD_RD, CMD_WR: w_raw = XW'(T_RW) + XW'(burst_length_i) + XW'(1);
      CMD_REF:        w_raw = XW'(T_RFC) * w_banks;
      CMD_ZQC:        w_raw = zqc_mode_i[0] ? XW'(T_ZQCL) : XW'(T_ZQCS);
      CMD_RESET:      w_raw = XW'(T_RESET);
      default:        w_raw = '0;
    endcase
    if (w_raw == '0) begin
      w_dur = CNT_W'(1);
    end else if (w_raw > MAX_D) begin
      w_dur = '1;
    end else begin
      w_dur = w_raw[CNT_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> ISSUE on a real command, ISSUE -> WAIT on PHY handshake,
  // WAIT -> IDLE once the counter has run down to zero.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_isInvalid) w_next = ISSUE;
      ISSUE:   if (issue_ready_i) w_next = WAIT;
      WAIT:    if (r_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    cmd_ready_o   = 1'b0;
    issue_valid_o = 1'b0;
    busy_o        = 1'b0;
    case (r_state)
      IDLE:    cmd_ready_o = 1'b1;
      ISSUE: begin
        issue_valid_o = 1'b1;
        busy_o        = 1'b1;
      end
      WAIT:    busy_o = 1'b1;
      default: cmd_ready_o = 1'b0;
    endcase
  end

  // Capture command and duration at accept, load and run down the wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cmd <= CMD_INVALID;
      r_dur <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && w_isInvalid;
      if (w_accept && !w_isInvalid) begin
        r_cmd <= cmd_decoded_i;
        r_dur <= w_dur;
      end
      if (w_issueHs) begin
        r_cnt <= r_dur - CNT_W'(1);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign issue_cmd_o   = r_cmd;
  assign err_invalid_o = r_err;

endmodule

// File: tb/tb_rpc_cmd_timer.sv
// Self-checking bench for rpc_cmd_timer: directed scenarios followed by a
// randomized command stream, each wait measured against a reference duration.

module tb_rpc_cmd_timer;
  import rpc_cmd_pkg::*;

  localparam int T_RP    = 4;
  localparam int T_RCD   = 6;
  localparam int T_MRD   = 4;
  localparam int T_RW    = 3;
  localparam int T_RFC   = 16;
  localparam int T_ZQCS  = 32;
  localparam int T_ZQCL  = 128;
  localparam int T_RESET = 200;
  localparam int CNT_W   = 12;
  localparam int BOUND   = 6000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmdValid;
  logic       cmdReady;
  logic [3:0] cmdDecoded;
  logic [5:0] burstLength;
  logic [1:0] zqcMode;
  logic [3:0] refBankNum;
  logic       issueValid;
  logic       issueReady;
  logic [3:0] issueCmd;
  logic       busy;
  logic       errInvalid;

  int checks = 0;
  int errors = 0;

  rpc_cmd_timer #(
    .T_RP(T_RP), .T_RCD(T_RCD), .T_MRD(T_MRD), .T_RW(T_RW), .T_RFC(T_RFC),
    .T_ZQCS(T_ZQCS), .T_ZQCL(T_ZQCL), .T_RESET(T_RESET), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cmd_valid_i(cmdValid),
    .cmd_ready_o(cmdReady),
    .cmd_decoded_i(cmdDecoded),
    .burst_length_i(burstLength),
    .zqc_mode_i(zqcMode),
    .ref_bank_num_i(refBankNum),
    .issue_valid_o(issueValid),
    .issue_ready_i(issueReady),
    .issue_cmd_o(issueCmd),
    .busy_o(busy),
    .err_invalid_o(errInvalid)
  );

  always #5 clk = ~clk;

  // Absolute time limit so a stuck DUT can never hang the run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference duration straight from the timing rules, using plain integers.
  function automatic int refDuration(input logic [3:0] code, input int bl, input int zq, input int rb);
    int d;
    case (code)
      CMD_PRE:        d = T_RP;
      CMD_ACT:        d = T_RCD;
      CMD_MRS:        d = T_MRD;
      CMD_RD, CMD_WR: d = T_RW + bl + 1;
      CMD_REF:        d = T_RFC * ((rb == 0) ? 1 : rb);
      CMD_ZQC:        d = (zq == 1 || zq == 3) ? T_ZQCL : T_ZQCS;
      CMD_RESET:      d = T_RESET;
      default:        d = 1;
    endcase
    if (d < 1) d = 1;
    if (d > (1 << CNT_W) - 1) d = (1 << CNT_W) - 1;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // While the DUT is busy, either hold the next command on the bus or throw junk at it.
  task automatic driveBusyInputs(input bit holdValid, input logic [3:0] holdCode);
    if (holdValid) begin
      cmdValid    = 1'b1;
      cmdDecoded  = holdCode;
      burstLength = '0;
      zqcMode     = '0;
      refBankNum  = '0;
    end else begin
      cmdValid    = 1'($urandom_range(0, 1));
      cmdDecoded  = 4'($urandom);
      burstLength = 6'($urandom);
      zqcMode     = 2'($urandom);
      refBankNum  = 4'($urandom);
    end
  endtask

  // One full command: accept, optional PHY stall, handshake, then measure the wait.
  task automatic applyStimulus(input logic [3:0] code, input int bl, input int zq, input int rb,
                               input int stall, input bit holdValid, input logic [3:0] holdCode);
    int d;
    int waited;
    d = refDuration(code, bl, zq, rb);
    checkOutput("ready_before_accept", 32'(cmdReady), 32'd1);
    cmdValid    = 1'b1;
    cmdDecoded  = code;
    burstLength = bl[5:0];
    zqcMode     = zq[1:0];
    refBankNum  = rb[3:0];
    issueReady  = (stall == 0);
    tick();
    driveBusyInputs(holdValid, holdCode);
    checkOutput("issue_valid", 32'(issueValid), 32'd1);
    checkOutput("issue_cmd", 32'(issueCmd), 32'(code));
    checkOutput("issue_ready_low", 32'(cmdReady), 32'd0);
    checkOutput("issue_busy", 32'(busy), 32'd1);
    for (int s = 0; s < stall; s++) begin
      tick();
      driveBusyInputs(holdValid, holdCode);
      checkOutput("stall_valid", 32'(issueValid), 32'd1);
      checkOutput("stall_cmd", 32'(issueCmd), 32'(code));
    end
    issueReady = 1'b1;
    tick();
    issueReady = 1'($urandom_range(0, 1));
    waited = 0;
    while (cmdReady !== 1'b1 && waited < BOUND) begin
      waited++;
      driveBusyInputs(holdValid, holdCode);
      checkOutput("wait_no_issue", 32'(issueValid), 32'd0);
      checkOutput("wait_busy", 32'(busy), 32'd1);
      tick();
    end
    checkOutput("wait_len", 32'(waited), 32'(d));
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_issue_valid", 32'(issueValid), 32'd0);
    if (!holdValid) cmdValid = 1'b0;
    issueReady = 1'b0;
  endtask

  // Present CMD_INVALID for one cycle and expect a single error pulse.
  task automatic applyInvalid();
    checkOutput("inv_ready_before", 32'(cmdReady), 32'd1);
    cmdValid    = 1'b1;
    cmdDecoded  = CMD_INVALID;
    burstLength = 6'($urandom);
    issueReady  = 1'($urandom_range(0, 1));
    tick();
    cmdValid = 1'b0;
    checkOutput("inv_err_pulse", 32'(errInvalid), 32'd1);
    checkOutput("inv_no_issue", 32'(issueValid), 32'd0);
    checkOutput("inv_ready", 32'(cmdReady), 32'd1);
    checkOutput("inv_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("inv_err_cleared", 32'(errInvalid), 32'd0);
    checkOutput("inv_ready_after", 32'(cmdReady), 32'd1);
    issueReady = 1'b0;
  endtask

  // Linear sequence of directed steps, then a randomized command stream.
  initial begin
    logic [3:0] codes [8];
    logic [3:0] pick;
    codes[0] = CMD_PRE;  codes[1] = CMD_ACT; codes[2] = CMD_MRS; codes[3] = CMD_RD;
    codes[4] = CMD_WR;   codes[5] = CMD_REF; codes[6] = CMD_ZQC; codes[7] = CMD_RESET;

    rst_n = 1'b0; cmdValid = 1'b0; cmdDecoded = '0; burstLength = '0;
    zqcMode = '0; refBankNum = '0; issueReady = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(cmdReady), 32'd1);
    checkOutput("rst_issue_valid", 32'(issueValid), 32'd0);
    checkOutput("rst_issue_cmd", 32'(issueCmd), 32'(CMD_INVALID));
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(errInvalid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("idle_ready", 32'(cmdReady), 32'd1);
      checkOutput("idle_valid", 32'(issueValid), 32'd0);
      checkOutput("idle_busy_q", 32'(busy), 32'd0);
      checkOutput("idle_err", 32'(errInvalid), 32'd0);
    end

    applyStimulus(CMD_ACT, 0, 0, 0, 0, 1'b0, CMD_INVALID);
    applyStimulus(CMD_RD, 7, 0, 0, 5, 1'b0, CMD_INVALID);
    applyStimulus(CMD_REF, 0, 0, 4, 0, 1'b0, CMD_INVALID);
    applyStimulus(CMD_REF, 0, 0, 0, 1, 1'b0, CMD_INVALID);
    applyStimulus(CMD_ZQC, 0, 1, 0, 0, 1'b0, CMD_INVALID);
    applyStimulus(CMD_ZQC, 0, 0, 0, 2, 1'b0, CMD_INVALID);
    applyStimulus(CMD_ZQC, 0, 2, 0, 0, 1'b0, CMD_INVALID);
    applyStimulus(CMD_ZQC, 0, 3, 0, 0, 1'b0, CMD_INVALID);
    applyInvalid();
    applyStimulus(CMD_PRE, 0, 0, 0, 0, 1'b1, CMD_ACT);
    applyStimulus(CMD_ACT, 0, 0, 0, 0, 1'b0, CMD_INVALID);
    applyStimulus(CMD_MRS, 0, 0, 0, 0, 1'b0, CMD_INVALID);
    applyStimulus(CMD_WR, 0, 0, 0, 0, 1'b0, CMD_INVALID);
    applyStimulus(CMD_WR, 63, 0, 0, 3, 1'b0, CMD_INVALID);
    applyStimulus(CMD_RESET, 0, 0, 0, 0, 1'b0, CMD_INVALID);

    cmdValid = 1'b1; cmdDecoded = CMD_REF; refBankNum = 4'd2; issueReady = 1'b1;
    tick();
    cmdValid = 1'b0;
    tick();
    repeat (19) tick();
    checkOutput("midref_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midref_rst_ready", 32'(cmdReady), 32'd1);
    checkOutput("midref_rst_valid", 32'(issueValid), 32'd0);
    checkOutput("midref_rst_cmd", 32'(issueCmd), 32'(CMD_INVALID));
    checkOutput("midref_rst_busy", 32'(busy), 32'd0);
    checkOutput("midref_rst_err", 32'(errInvalid), 32'd0);
    issueReady = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(CMD_PRE, 0, 0, 0, 0, 1'b0, CMD_INVALID);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        applyInvalid();
      end else begin
        pick = codes[$urandom_range(0, 7)];
        applyStimulus(pick, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0, CMD_INVALID);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
